rr_grant_ctrl: RTL

Round-robin arbiter that shares one resource between `N` requesters. Each requester raises `req[i]` and holds it; the block issues a registered one-hot grant, so a request seen idle is granted in the next cycle (`req |=> gnt`). A hold timer bounds how long one owner keeps the resource. The block ships with embedded SVA properties so it can be proven formally alongside the other demos.

---
 rtl/arb_pkg.sv | 35 +++
 rtl/rr_pick_mask.sv | 36 +++
 rtl/rr_grant_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared arbiter types plus a loop-based reference search.
// The reference search is used to cross-check the rotate/find picker.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWN
    } arb_state_e;

    localparam int unsigned ARB_MAX_N = 16;

    // Returns {valid, index}. The search starts at ptr, wraps modulo n and skips excluded bits.
    function automatic logic [4:0] rr_pick(
        input logic [ARB_MAX_N-1:0] req,
        input logic [3:0]           ptr,
        input logic [ARB_MAX_N-1:0] exclude,
        input int unsigned          n
    );
        logic [4:0]  res;
        int unsigned idx;
        logic [3:0]  idx4;
        res = '0;
        for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
            if (i < n) begin
                idx  = (32'(ptr) + i) % n;
                idx4 = idx[3:0];
                if (!res[4] && req[idx4] && !exclude[idx4]) begin
                    res = {1'b1, idx4};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick_mask.sv
// Combinational round-robin picker.
// It rotates the masked requests by ptr, finds the lowest set bit, then un-rotates the index.
module rr_pick_mask #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic [N-1:0]  excl_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    localparam logic [IW:0] N_C = (IW+1)'(N);

    logic [N-1:0]   masked;
    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    always_comb begin
        masked  = req_i & ~excl_i;
        doubled = {masked, masked} >> ptr_i;
        rotated = doubled[N-1:0];
        valid_o = |rotated;
        off     = '0;
        // Descending scan so the lowest set offset is the last one written.
        for (int unsigned j = N; j > 0; j--) begin
            if (rotated[j-1]) off = IW'(j-1);
        end
        sum   = {1'b0, ptr_i} + {1'b0, off};
        idx_o = (sum >= N_C) ? IW'(sum - N_C) : sum[IW-1:0];
    end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller with a registered one-hot grant and a per-owner hold limit.
// Embedded properties cover grant shape, request causality, idle response and a liveness bound.
module rr_grant_ctrl
    import arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy
);

    localparam int unsigned   IW         = $clog2(N);
    localparam int unsigned   HW         = $clog2(MAX_HOLD+1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST_ID    = IW'(N-1);
    localparam int unsigned   LIVE_BOUND = N * (MAX_HOLD + 1);
    localparam logic [N-1:0]  FIRST_GNT  = N'(1);
    localparam logic [N-1:0]  LAST_GNT   = FIRST_GNT << (N-1);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] id_q, id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          busy_q, busy_d;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          owner_req;
    logic          do_pick;

    // The current grant doubles as the exclusion mask; it is all-zero while idle.
    rr_pick_mask #(.N(N), .IW(IW)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .excl_i  (gnt_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        owner_req = |(req & gnt_q);
        do_pick   = 1'b0;

        if (state_q == ARB_IDLE) begin
            do_pick = 1'b1;
        end else if (owner_req && hold_q < HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
        end else begin
            do_pick = 1'b1;
        end

        if (do_pick) begin
            if (pick_valid) begin
                state_d         = ARB_OWN;
                gnt_d           = '0;
                gnt_d[pick_idx] = 1'b1;
                id_d            = pick_idx;
                ptr_d           = (pick_idx == LAST_ID) ? '0 : pick_idx + 1'b1;
                hold_d          = HW'(1);
                busy_d          = 1'b1;
            end else begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                id_d    = '0;
                hold_d  = '0;
                busy_d  = 1'b0;
            end
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = id_q;
    assign busy   = busy_q;

    logic [ARB_MAX_N-1:0] req_ext;
    logic [ARB_MAX_N-1:0] gnt_ext;
    logic [4:0]           ref_pick;

    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req;
        gnt_ext          = '0;
        gnt_ext[N-1:0]   = gnt_q;
        ref_pick         = rr_pick(req_ext, 4'(ptr_q), gnt_ext, N);
    end

    a_onehot:  assert property (@(posedge clock) disable iff (reset) $onehot0(gnt));
    a_busy:    assert property (@(posedge clock) disable iff (reset) busy == |gnt);
    a_cause:   assert property (@(posedge clock) disable iff (reset) (gnt & ~$past(req)) == '0);
    a_idle:    assert property (@(posedge clock) disable iff (reset)
                                (state_q == ARB_IDLE && req != '0) |=> gnt != '0);
    a_hold:    assert property (@(posedge clock) disable iff (reset) hold_q <= HOLD_MAX);
    a_picker:  assert property (@(posedge clock) disable iff (reset)
                                ref_pick[4] == pick_valid && (!pick_valid || ref_pick[3:0] == 4'(pick_idx)));
    c_wrap:    cover property (@(posedge clock) disable iff (reset)
                                $past(gnt) == LAST_GNT && gnt == FIRST_GNT);

    // Each requester counts consecutive cycles spent waiting with its request held.
    for (genvar i = 0; i < N; i++) begin : g_live
        logic [31:0] wait_q;
        always_ff @(posedge clock) begin
            if (reset || !req[i] || gnt[i]) begin
                wait_q <= '0;
            end else if (wait_q < LIVE_BOUND) begin
                wait_q <= wait_q + 1'b1;
            end
        end
        a_live: assert property (@(posedge clock) disable iff (reset) wait_q < LIVE_BOUND);
    end

endmodule
